regfile_write_port: RTL

- Write side of the 32 x 64-bit register file; pairs with the 32:1 read mux.
- Decodes a 5-bit write address into 32 one-hot enables.
- Holds the 32 architectural registers in enabled D flip-flops.
- Presents all 32 register values as an unpacked array that feeds the read-mux inputs directly. Also reports write acknowledge and a write counter.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_write_port_if.sv | 32 +++
 rtl/decoder_5to32.sv | 42 ++++
 rtl/regfile_write_port.sv | 87 ++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 64-bit register file write side.
package regfile_pkg;

    localparam int DATA_W       = 64;
    localparam int NUM_REGS     = 32;
    localparam int ADDR_W       = 5;
    localparam int ZERO_REG_IDX = 31;
    localparam int CNT_W        = 16;

    typedef logic [DATA_W-1:0] reg_word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]  wr_cnt_t;

endpackage : regfile_pkg

// File: rtl/regfile_write_port_if.sv
// Write-port bundle: write request in, register contents / ack / count out.
// The master drives writes and observes the register file; the slave is the
// register file itself.
interface regfile_write_port_if;
    import regfile_pkg::*;

    logic      wr_en;
    reg_addr_t wr_addr;
    reg_word_t wr_data;
    reg_word_t regs [NUM_REGS-1:0];
    logic      wr_ack;
    wr_cnt_t   wr_count;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  regs,
        input  wr_ack,
        input  wr_count
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output regs,
        output wr_ack,
        output wr_count
    );

endinterface : regfile_write_port_if

// File: rtl/decoder_5to32.sv
// 5-to-32 one-hot write-enable decoder. The low address pair goes through a
// 2-to-4 stage; the upper three bits form a 3-to-8 stage built from a second
// 2-to-4 stage on addr[3:2] split by addr[4]. The final enable is the AND of
// the 3-to-8 and low 2-to-4 outputs, mirroring the read-mux tree.
// With en low every output is 0 regardless of addr, so unknown addresses
// while idle cannot select a register.
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic                en,
    input  reg_addr_t           addr,
    output logic [NUM_REGS-1:0] onehot
);

    logic [3:0] dec_lo;   // addr[1:0]
    logic [3:0] dec_mid;  // addr[3:2]
    logic [7:0] dec_hi;   // addr[4:2], qualified by en

    // Two-level decode tree producing the one-hot enable vector.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves a value unassigned and a latch is never inferred.
        dec_lo  = '0;
        dec_mid = '0;
        dec_hi  = '0;
        onehot  = '0;

        for (int k = 0; k < 4; k++) begin
            dec_lo[k]  = (addr[1:0] == 2'(k));
            dec_mid[k] = (addr[3:2] == 2'(k));
        end

        for (int k = 0; k < 8; k++) begin
            dec_hi[k] = en & (addr[4] == k[2]) & dec_mid[k[1:0]];
        end

        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = dec_hi[i[4:2]] & dec_lo[i[1:0]];
        end
    end

endmodule : decoder_5to32

// File: rtl/regfile_write_port.sv
// Write side of the 32 x 64-bit register file. Decodes the write address,
// stores the architectural registers in enabled flip-flops and exposes all of
// them as an unpacked array for the external 32:1 read mux. Also reports a
// one-cycle write acknowledge and a wrapping count of accepted writes.
//
// Build option: define ZERO_REG_EN to hardwire register 31 (XZR) to zero.
// Writes to it are still accepted (ack and count advance) but are discarded.
module regfile_write_port
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    regfile_write_port_if.slave  wr
);

`ifdef ZERO_REG_EN
    localparam bit HAS_ZERO_REG = 1'b1;
`else
    localparam bit HAS_ZERO_REG = 1'b0;
`endif

    logic [NUM_REGS-1:0] wr_sel;
    reg_word_t           regs_w [NUM_REGS-1:0];

    logic    ack_q, ack_d;
    wr_cnt_t cnt_q, cnt_d;

    decoder_5to32 u_decoder (
        .en     (wr.wr_en),
        .addr   (wr.wr_addr),
        .onehot (wr_sel)
    );

    // One storage register per index; the hardwired zero register, when
    // enabled, is a constant with no flops behind it.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (HAS_ZERO_REG && (i == ZERO_REG_IDX)) begin : g_zero
            logic unused_sel;
            assign unused_sel = wr_sel[i];
            assign regs_w[i]  = '0;
        end else begin : g_store
            reg_word_t word_q;

            // Enabled D register: load on a decoded write, otherwise hold.
            always_ff @(posedge clk or posedge reset) begin
                // NOTE: these are architectural registers that must read as
                // zero the instant reset rises, so every word is reset here
                // rather than being left as an unreset memory array.
                if (reset) begin
                    word_q <= '0;
                end else if (wr_sel[i]) begin
                    // NOTE: sequential state always uses non-blocking
                    // assignment so every flop samples pre-edge values.
                    word_q <= wr.wr_data;
                end
            end

            assign regs_w[i] = word_q;
        end
    end

    assign wr.regs = regs_w;

    // Next-state for the acknowledge pulse and the accepted-write counter.
    always_comb begin
        ack_d = wr.wr_en;
        cnt_d = cnt_q;
        if (wr.wr_en) begin
            cnt_d = cnt_q + wr_cnt_t'(1);
        end
    end

    // Status registers: ack follows acceptance by one cycle, counter wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ack_q <= ack_d;
            cnt_q <= cnt_d;
        end
    end

    assign wr.wr_ack   = ack_q;
    assign wr.wr_count = cnt_q;

endmodule : regfile_write_port
